ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to a keyboard or mouse, e.g. 0xED set-LEDs or 0xFF reset.
- Performs inhibit, request-to-send, device-clocked serialisation, odd parity, stop bit and acknowledge check.
- Drives the shared PS/2 lines through open-drain enables. Sits beside the existing PS/2 receiver on the same pins.
- BUSY tells the receiver to ignore line activity during a transmission.

Parameters:
- FILTER_LEN, 8: PS2_CLK glitch-filter depth in CLK cycles. The filtered level changes only when all samples agree.
- INHIBIT_CYCLES, 6000: CLK cycles that PS2_CLK is held low before request-to-send. 120 us at 50 MHz.
- TIMEOUT_CYCLES, 1000000: maximum CLK cycles between device clock edges before abort. 20 ms at 50 MHz.

Ports:
- CLK  in  1  system clock
- nRESET  in  1  asynchronous, active-low reset
- PS2_CLK_IN  in  1  sampled PS/2 clock line
- PS2_DATA_IN  in  1  sampled PS/2 data line
- PS2_CLK_OE  out  1  1 = pull PS/2 clock low, 0 = release
- PS2_DATA_OE  out  1  1 = pull PS/2 data low, 0 = release
- DATA  in  8  byte to send; sampled on the WRITE cycle
- WRITE  in  1  one-cycle request strobe
- BUSY  out  1  transmission in progress
- DONE  out  1  one-cycle pulse: byte sent and device acknowledged
- ERROR  out  1  one-cycle pulse: no acknowledge or timeout

Behaviour:
- Reset is asynchronous, active-low nRESET; clock is CLK. Reset values: PS2_CLK_OE=0, PS2_DATA_OE=0, BUSY=0, DONE=0, ERROR=0, state IDLE, filter all ones, counters 0.
- Reset mid-operation releases both lines immediately; the partial frame is abandoned.
- Inputs are registered. PS2_CLK_IN is filtered as described under FILTER_LEN. A falling-edge pulse (fall) is generated for one CLK when the filtered level goes 1 to 0.
- BUSY = (state != IDLE), registered.
- WRITE is accepted only in IDLE. WRITE while BUSY is ignored, with no queueing.
- IDLE: both OE=0. On WRITE: latch DATA into shreg[7:0] and set shreg[8] = ~^DATA (odd parity). Clear cycle counter and go to INHIBIT.
- INHIBIT: PS2_CLK_OE=1. After INHIBIT_CYCLES cycles, set PS2_DATA_OE=1 (start bit 0) and go to RTS.
- RTS: one cycle with both lines low. Then PS2_CLK_OE=0 and go to SEND with bitcnt=0.
- SEND: on each fall, drive PS2_DATA_OE = ~shreg[0], shift shreg right filling with 1, and increment bitcnt.
  - Falls 1-8 present data bits LSB first.
  - Fall 9 presents parity.
  - Fall 10 presents the stop bit (DATA_OE=0).
  - After fall 10 go to ACK.
- ACK: on the next fall, sample registered PS2_DATA_IN. 0 sets ack_ok=1, 1 sets ack_ok=0. Go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock = 1 and registered data = 1. Then pulse DONE if ack_ok, else ERROR, and go to IDLE. BUSY falls in the same cycle as the pulse.
- Timeout: in SEND, ACK and WAIT_IDLE, a counter clears on every fall. If it reaches TIMEOUT_CYCLES: release both lines, pulse ERROR, go to IDLE.
- DONE and ERROR are never asserted together.
- Latency from WRITE to the first low on PS2_CLK_OE is 1 cycle.

Decomposition:
- Shared package ps2_pkg holds:
  - the tx state enum (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE);
  - constant PS2_FRAME_BITS=11;
  - constant PS2_TX_SHIFT_BITS=10;
  - an odd-parity function.
- One sub-module, ps2_clk_filter (FILTER_LEN; outputs level, fall, rise). It is also reusable by the receiver.

Test Plan:
- Device model clocks at 12.5 kHz. WRITE DATA=0xED -> PS2_CLK_OE high for exactly 6000 cycles, then data low. Device samples on rising edges: 0,1,0,1,1,0,1,1,1 (start + LSB-first bits), parity=1, stop=1. Device acks 0 -> DONE for 1 cycle, BUSY 0.
- DATA=0x00 -> parity sampled 1. DATA=0xFF -> parity sampled 0. Both produce DONE.
- Device leaves data high in the ack slot -> ERROR for 1 cycle, no DONE, both OE=0.
- Device stops clocking after 4 falls -> ERROR exactly TIMEOUT_CYCLES after the last fall, lines released, BUSY 0.
- Second WRITE (0xF4) during the transmission of 0xED -> only 0xED appears on the wire; one DONE.
- Inject 5-cycle low glitches on PS2_CLK_IN during SEND -> no bit advance, frame intact.
- nRESET low during SEND -> OEs 0 asynchronously. A following WRITE of 0xFF completes with DONE.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame sizes and parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    // Full frame on the wire: start, 8 data, parity, stop.
    localparam int PS2_FRAME_BITS    = 11;
    // Bits the host shifts out after the start bit: 8 data, parity, stop.
    localparam int PS2_TX_SHIFT_BITS = 10;

    // Parity bit that makes the total number of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock deglitcher: the filtered level only moves when FILTER_LEN consecutive
// samples agree; one-cycle fall/rise pulses mark each change of the filtered level.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic CLK,
    input  logic nRESET,
    input  logic din,
    output logic level,
    output logic fall,
    output logic rise
);

    logic [FILTER_LEN-1:0] hist;

    // Shift in samples and switch the level once the whole window agrees.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            hist  <= '1;
            level <= 1'b1;
            fall  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            hist <= {hist[FILTER_LEN-2:0], din};
            fall <= 1'b0;
            rise <= 1'b0;
            if (level && (hist == '0)) begin
                level <= 1'b0;
                fall  <= 1'b1;
            end else if (!level && (hist == '1)) begin
                level <= 1'b1;
                rise  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, requests to send, then shifts
// one byte plus odd parity and stop on device-generated clock falls and checks the ack.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | lines released, waiting for WRITE
// INHIBIT   | clock held low for INHIBIT_CYCLES
// RTS       | clock and data both low for one cycle (start bit on data)
// SEND      | device clocking; each fall presents next data/parity/stop bit
// ACK       | next fall samples the device acknowledge on data
// WAIT_IDLE | wait for clock and data both high, then report DONE or ERROR
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    input  logic [7:0] DATA,
    input  logic       WRITE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR
);

    localparam int MAX_CYCLES = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int BITCNT_W   = $clog2(PS2_FRAME_BITS);

    localparam logic [CNT_W-1:0]    INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BITCNT_W-1:0] SEND_LAST    = BITCNT_W'(PS2_TX_SHIFT_BITS - 1);

    ps2_tx_state_t                 state;
    logic [PS2_TX_SHIFT_BITS-1:0]  shreg;
    logic [BITCNT_W-1:0]           bitcnt;
    logic [CNT_W-1:0]              cnt;
    logic                          ack_ok;

    logic clk_r;
    logic data_r;
    logic clk_level;
    logic clk_fall;
    logic clk_rise_unused;

    // Register the raw bus lines before anything looks at them.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            clk_r  <= 1'b1;
            data_r <= 1'b1;
        end else begin
            clk_r  <= PS2_CLK_IN;
            data_r <= PS2_DATA_IN;
        end
    end

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .CLK    (CLK),
        .nRESET (nRESET),
        .din    (clk_r),
        .level  (clk_level),
        .fall   (clk_fall),
        .rise   (clk_rise_unused)
    );

    // Transmit sequencer; all bus enables and status flags are registered here.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state       <= IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            cnt         <= '0;
            ack_ok      <= 1'b0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERROR       <= 1'b0;
        end else begin
            DONE  <= 1'b0;
            ERROR <= 1'b0;
            case (state)
                IDLE: begin
                    PS2_CLK_OE  <= 1'b0;
                    PS2_DATA_OE <= 1'b0;
                    if (WRITE) begin
                        // Stop bit rides in the top of the shifter so it falls out after parity.
                        shreg      <= {1'b1, odd_parity(DATA), DATA};
                        cnt        <= '0;
                        PS2_CLK_OE <= 1'b1;
                        BUSY       <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    PS2_CLK_OE <= 1'b1;
                    if (cnt == INHIBIT_LAST) begin
                        PS2_DATA_OE <= 1'b1;
                        state       <= RTS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RTS: begin
                    PS2_CLK_OE <= 1'b0;
                    bitcnt     <= '0;
                    cnt        <= '0;
                    state      <= SEND;
                end
                SEND, ACK, WAIT_IDLE: begin
                    if ((state == WAIT_IDLE) && clk_level && data_r) begin
                        DONE  <= ack_ok;
                        ERROR <= ~ack_ok;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else if (clk_fall) begin
                        cnt <= '0;
                        if (state == SEND) begin
                            PS2_DATA_OE <= ~shreg[0];
                            shreg       <= {1'b1, shreg[PS2_TX_SHIFT_BITS-1:1]};
                            bitcnt      <= bitcnt + 1'b1;
                            if (bitcnt == SEND_LAST) begin
                                state <= ACK;
                            end
                        end else if (state == ACK) begin
                            ack_ok <= ~data_r;
                            state  <= WAIT_IDLE;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        // Device went quiet: abandon the frame and free the bus.
                        PS2_CLK_OE  <= 1'b0;
                        PS2_DATA_OE <= 1'b0;
                        ERROR       <= 1'b1;
                        BUSY        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    PS2_CLK_OE  <= 1'b0;
                    PS2_DATA_OE <= 1'b0;
                    BUSY        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
